// File: rtl/core_mem_ctrl_pkg.sv
// Shared types for the core-to-main-memory controller: block address/data,
// dcache request type, controller FSM states and requester identity.
package core_mem_ctrl_pkg;

  typedef logic [25:0]  main_mem_block_addr_t;
  typedef logic [127:0] block_data_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } mem_ctrl_state_t;

  typedef enum logic {
    SRC_IC,
    SRC_DC
  } mem_ctrl_src_t;

endpackage

// File: rtl/core_mem_ctrl_if.sv
// Core icache/dcache request ports plus the main-memory port of core_mem_ctrl.
// master = controller view, slave = core + main-memory view.
interface core_mem_ctrl_if;
  import core_mem_ctrl_pkg::*;

  logic                 ic_req_valid;
  main_mem_block_addr_t ic_req_block_addr;
  logic                 ic_req_ready;
  logic                 ic_resp_valid;
  block_data_t          ic_resp_block_data;

  logic                 dc_req_valid;
  req_type_t            dc_req_type;
  main_mem_block_addr_t dc_req_block_addr;
  block_data_t          dc_req_block_data;
  logic                 dc_req_ready;
  logic                 dc_resp_valid;
  block_data_t          dc_resp_block_data;

  logic                 mem_req_valid;
  logic                 mem_req_we;
  main_mem_block_addr_t mem_req_block_addr;
  block_data_t          mem_req_block_data;
  logic                 mem_req_ready;
  logic                 mem_resp_valid;
  block_data_t          mem_resp_block_data;

  modport master (
    input  ic_req_valid, ic_req_block_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_block_data,
    input  dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data,
    output dc_req_ready, dc_resp_valid, dc_resp_block_data,
    output mem_req_valid, mem_req_we, mem_req_block_addr, mem_req_block_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_block_data
  );

  modport slave (
    output ic_req_valid, ic_req_block_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_block_data,
    output dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data,
    input  dc_req_ready, dc_resp_valid, dc_resp_block_data,
    input  mem_req_valid, mem_req_we, mem_req_block_addr, mem_req_block_data,
    output mem_req_ready, mem_resp_valid, mem_resp_block_data
  );

endinterface

// File: rtl/core_mem_ctrl_arb2.sv
// Two-way icache/dcache grant, combinational; round-robin on last_grant, or strict
// dcache priority when CORE_MEM_CTRL_DC_PRIO_EN is defined. Grants only valid requesters.
module mem_ctrl_arb2
  import core_mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_aH,
  input  logic i_ic_vld,
  input  logic i_dc_vld,
  input  logic i_accept,
  output logic o_grant_ic,
  output logic o_grant_dc
);

`ifdef CORE_MEM_CTRL_DC_PRIO_EN
  logic w_unused_prio;

  assign w_unused_prio = ^{clk, rst_aH, i_accept};
  assign o_grant_dc    = i_dc_vld;
  assign o_grant_ic    = i_ic_vld & ~i_dc_vld;
`else
  mem_ctrl_src_t r_last_grant;

  // On a tie the source that did not win last time gets the grant.
  assign o_grant_ic = i_ic_vld & (~i_dc_vld | (r_last_grant == SRC_DC));
  assign o_grant_dc = i_dc_vld & (~i_ic_vld | (r_last_grant == SRC_IC));

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      r_last_grant <= SRC_DC;
    end else if (i_accept) begin
      r_last_grant <= o_grant_dc ? SRC_DC : SRC_IC;
    end
  end
`endif

endmodule

// File: rtl/core_mem_ctrl.sv
// Serves icache/dcache block requests from one main-memory port, one transaction in flight;
// response pulse 4 cycles after handshake at best; no resp backpressure. Optional CORE_MEM_CTRL_DC_PRIO_EN.
module core_mem_ctrl
  import core_mem_ctrl_pkg::*;
#(
  parameter int BLOCK_ADDR_W   = $bits(main_mem_block_addr_t),
  parameter int BLOCK_DATA_W   = $bits(block_data_t),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst_aH,
  core_mem_ctrl_if.master bus,
  output logic           timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_ctrl_state_t         r_state;
  mem_ctrl_src_t           r_src;
  logic                    r_we;
  logic [BLOCK_ADDR_W-1:0] r_addr;
  logic [BLOCK_DATA_W-1:0] r_wdata;
  logic [BLOCK_DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic                    r_mem_req_valid;
  logic                    r_ic_resp_valid;
  logic                    r_dc_resp_valid;
  logic [BLOCK_DATA_W-1:0] r_ic_resp_data;
  logic [BLOCK_DATA_W-1:0] r_dc_resp_data;
  logic                    r_timeout_err;

  logic w_idle;
  logic w_grant_ic;
  logic w_grant_dc;
  logic w_accept;

  mem_ctrl_arb2 u_arb (
    .clk        (clk),
    .rst_aH     (rst_aH),
    .i_ic_vld   (bus.ic_req_valid),
    .i_dc_vld   (bus.dc_req_valid),
    .i_accept   (w_accept),
    .o_grant_ic (w_grant_ic),
    .o_grant_dc (w_grant_dc)
  );

  // Ready is only offered in IDLE and is forced low while reset is held.
  assign w_idle            = (r_state == IDLE) & ~rst_aH;
  assign bus.ic_req_ready  = w_idle & w_grant_ic;
  assign bus.dc_req_ready  = w_idle & w_grant_dc;
  assign w_accept          = bus.ic_req_ready | bus.dc_req_ready;

  assign bus.ic_resp_valid      = r_ic_resp_valid;
  assign bus.ic_resp_block_data = r_ic_resp_data;
  assign bus.dc_resp_valid      = r_dc_resp_valid;
  assign bus.dc_resp_block_data = r_dc_resp_data;
  assign bus.mem_req_valid      = r_mem_req_valid;
  assign bus.mem_req_we         = r_we;
  assign bus.mem_req_block_addr = r_addr;
  assign bus.mem_req_block_data = r_wdata;
  assign timeout_err            = r_timeout_err;

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      r_state         <= IDLE;
      r_src           <= SRC_IC;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_rdata         <= '0;
      r_wait_cnt      <= '0;
      r_mem_req_valid <= 1'b0;
      r_ic_resp_valid <= 1'b0;
      r_dc_resp_valid <= 1'b0;
      r_ic_resp_data  <= '0;
      r_dc_resp_data  <= '0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_ic_resp_valid <= 1'b0;
      r_dc_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_src           <= w_grant_dc ? SRC_DC : SRC_IC;
            r_we            <= w_grant_dc & (bus.dc_req_type == REQ_WRITE);
            r_addr          <= w_grant_dc ? bus.dc_req_block_addr : bus.ic_req_block_addr;
            r_wdata         <= w_grant_dc ? bus.dc_req_block_data : '0;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_wait_cnt      <= '0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          // A response on the last allowed cycle still beats the timeout.
          if (bus.mem_resp_valid) begin
            r_rdata <= r_we ? '0 : bus.mem_resp_block_data;
            r_state <= RESP;
          end else if (r_wait_cnt == CNT_LAST) begin
            r_rdata       <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (r_src == SRC_DC) begin
            r_dc_resp_valid <= 1'b1;
            r_dc_resp_data  <= r_rdata;
          end else begin
            r_ic_resp_valid <= 1'b1;
            r_ic_resp_data  <= r_rdata;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_ctrl.sv
// Self-checking bench for core_mem_ctrl: directed scenarios then random transactions
// against a transaction-level model (arbitration, latency, memory contents, sticky timeout).
module tb_core_mem_ctrl;
  import core_mem_ctrl_pkg::*;

  localparam int TO_CYC = 4;
`ifdef CORE_MEM_CTRL_DC_PRIO_EN
  localparam bit DC_PRIO = 1'b1;
`else
  localparam bit DC_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_aH = 1'b1;
  logic timeout_err;
  int   n_assert = 0;
  int   n_fail = 0;

  core_mem_ctrl_if bus ();

  core_mem_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk         (clk),
    .rst_aH      (rst_aH),
    .bus         (bus.master),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference state
  block_data_t mem_model [main_mem_block_addr_t];
  bit          last_dc;
  bit          to_seen;
  block_data_t last_ic_data;
  block_data_t last_dc_data;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input block_data_t obs, input block_data_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic block_data_t rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic block_data_t mem_rd(input main_mem_block_addr_t a);
    if (!mem_model.exists(a)) mem_model[a] = rnd_data();
    return mem_model[a];
  endfunction

  task automatic model_reset();
    last_dc      = 1'b1;
    to_seen      = 1'b0;
    last_ic_data = '0;
    last_dc_data = '0;
  endtask

  task automatic spur();
    bus.mem_resp_valid      = ($urandom_range(0, 2) == 0);
    bus.mem_resp_block_data = rnd_data();
  endtask

  task automatic clear_inputs();
    bus.ic_req_valid        = 1'b0;
    bus.ic_req_block_addr   = '0;
    bus.dc_req_valid        = 1'b0;
    bus.dc_req_type         = REQ_READ;
    bus.dc_req_block_addr   = '0;
    bus.dc_req_block_data   = '0;
    bus.mem_req_ready       = 1'b0;
    bus.mem_resp_valid      = 1'b0;
    bus.mem_resp_block_data = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_b({tag, "_ic_rdy"},  bus.ic_req_ready, 1'b0);
    chk_b({tag, "_dc_rdy"},  bus.dc_req_ready, 1'b0);
    chk_b({tag, "_ic_resp"}, bus.ic_resp_valid, 1'b0);
    chk_b({tag, "_dc_resp"}, bus.dc_resp_valid, 1'b0);
    chk_w({tag, "_ic_data"}, bus.ic_resp_block_data, '0);
    chk_w({tag, "_dc_data"}, bus.dc_resp_block_data, '0);
    chk_b({tag, "_mem_vld"}, bus.mem_req_valid, 1'b0);
    chk_b({tag, "_mem_we"},  bus.mem_req_we, 1'b0);
    chk_w({tag, "_mem_addr"}, 128'(bus.mem_req_block_addr), '0);
    chk_w({tag, "_mem_wdat"}, bus.mem_req_block_data, '0);
    chk_b({tag, "_tmo"},     timeout_err, 1'b0);
  endtask

  // Holds reset for one full cycle; returns at posedge+1 with reset released.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst_aH = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk_all_zero(tag);
    @(posedge clk); #1;
    rst_aH = 1'b0;
    model_reset();
  endtask

  // Entered at posedge+1 of the handshake cycle with the DUT idle; returns at
  // posedge+1 of the response-pulse cycle so the next call exercises back-to-back.
  task automatic do_txn(input bit want_ic, input bit want_dc, input bit dc_we,
                        input main_mem_block_addr_t ic_addr, input main_mem_block_addr_t dc_addr,
                        input block_data_t wdata, input int rd, input int wd);
    bit win_dc, to, wr;
    int lat;
    main_mem_block_addr_t exp_addr;
    block_data_t rdata, exp_data;
    win_dc   = want_dc && (!want_ic || DC_PRIO || !last_dc);
    wr       = win_dc && dc_we;
    to       = (wd >= TO_CYC);
    lat      = to ? rd + TO_CYC + 3 : rd + wd + 4;
    exp_addr = win_dc ? dc_addr : ic_addr;
    rdata    = wr ? '0 : mem_rd(exp_addr);
    exp_data = (wr || to) ? '0 : rdata;

    bus.ic_req_valid      = want_ic;
    bus.ic_req_block_addr = ic_addr;
    bus.dc_req_valid      = want_dc;
    bus.dc_req_type       = dc_we ? REQ_WRITE : REQ_READ;
    bus.dc_req_block_addr = dc_addr;
    bus.dc_req_block_data = wdata;
    bus.mem_req_ready     = 1'b0;
    spur();
    @(negedge clk);
    chk_b("ic_req_ready", bus.ic_req_ready, !win_dc);
    chk_b("dc_req_ready", bus.dc_req_ready, win_dc);

    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      bus.ic_req_valid = 1'b0;
      bus.dc_req_valid = 1'b0;
      if (c <= rd + 1) begin
        chk_b("mem_req_valid", bus.mem_req_valid, 1'b1);
        chk_w("mem_req_addr", 128'(bus.mem_req_block_addr), 128'(exp_addr));
        chk_b("mem_req_we", bus.mem_req_we, wr);
        if (wr) chk_w("mem_req_data", bus.mem_req_block_data, wdata);
      end else if (c == rd + 2) begin
        chk_b("mem_req_drop", bus.mem_req_valid, 1'b0);
      end
      chk_b("ic_resp_valid", bus.ic_resp_valid, (c == lat) && !win_dc);
      chk_b("dc_resp_valid", bus.dc_resp_valid, (c == lat) && win_dc);
      bus.mem_req_ready = (c == rd + 1);
      if (c <= rd + 1) begin
        spur();
      end else begin
        bus.mem_resp_valid      = !to && (c == rd + 2 + wd);
        bus.mem_resp_block_data = (bus.mem_resp_valid && !wr) ? rdata : rnd_data();
      end
    end

    if (win_dc) last_dc_data = exp_data;
    else        last_ic_data = exp_data;
    if (wr && !to) mem_model[dc_addr] = wdata;
    to_seen = to_seen | to;
    last_dc = win_dc;
    chk_w("ic_resp_data", bus.ic_resp_block_data, last_ic_data);
    chk_w("dc_resp_data", bus.dc_resp_block_data, last_dc_data);
    chk_b("timeout_err", timeout_err, to_seen);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk_b("idle_ic_resp", bus.ic_resp_valid, 1'b0);
      chk_b("idle_dc_resp", bus.dc_resp_valid, 1'b0);
      chk_b("idle_mem_vld", bus.mem_req_valid, 1'b0);
      chk_w("idle_ic_hold", bus.ic_resp_block_data, last_ic_data);
      chk_w("idle_dc_hold", bus.dc_resp_block_data, last_dc_data);
      spur();
    end
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    int w;
    clear_inputs();
    model_reset();
    do_reset("rst");

    // Single icache read, fastest memory.
    mem_model[26'h40] = {16{8'hA5}};
    do_txn(1'b1, 1'b0, 1'b0, 26'h40, '0, '0, 0, 0);
    idle(2);

    // dcache write, memory ready delayed 3 cycles.
    do_txn(1'b0, 1'b1, 1'b1, '0, 26'h10, {4{32'hDEADBEEF}}, 3, 1);
    idle(1);

    // Timeout, then an immediate back-to-back request.
    do_txn(1'b1, 1'b0, 1'b0, 26'h7, '0, '0, 0, TO_CYC);
    do_txn(1'b0, 1'b1, 1'b0, '0, 26'h10, '0, 1, 2);

    // Reset while waiting for memory; stale response afterwards must be ignored.
    bus.ic_req_valid      = 1'b1;
    bus.ic_req_block_addr = 26'h20;
    @(negedge clk);
    chk_b("rw_ic_ready", bus.ic_req_ready, 1'b1);
    @(posedge clk); #1;
    bus.ic_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_aH = 1'b1;
    @(negedge clk);
    chk_all_zero("rw");
    @(posedge clk); #1;
    rst_aH                  = 1'b0;
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_block_data = rnd_data();
    model_reset();
    @(negedge clk);
    chk_b("rw_stale_mem_vld", bus.mem_req_valid, 1'b0);
    idle(5);

    // Ties right after reset: round-robin alternates starting with icache.
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b1, 1'b1, i[0], 26'(8 + i), 26'(12 + i), rnd_data(), i % 2, i % 3);
    end
    idle(1);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(1, 3);
      do_txn(w[0], w[1], $urandom_range(0, 1) == 1,
             26'($urandom_range(0, 15)), 26'($urandom_range(0, 15)), rnd_data(),
             $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? TO_CYC + 1 : $urandom_range(0, TO_CYC - 1));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
